// File: rtl/nasti_mem_slave_if.sv
// nasti_channel: NASTI (AXI4) channel bundle shared by a master and a slave.
//   AW/AR : id, addr, len, size, burst, lock, cache, prot, valid (master) / ready (slave)
//   W     : data, strb, last, valid (master) / ready (slave)
//   B     : id, resp, user, valid (slave) / ready (master)
//   R     : id, data, resp, last, user, valid (slave) / ready (master)
// Handshake rule for every channel: a transfer happens on a rising clock edge
// where valid && ready are both high; once valid is raised, the payload holds
// stable until that edge, and valid never waits on ready.
interface nasti_channel #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter int ID_WIDTH   = 1
);
  logic [ID_WIDTH-1:0]     aw_id;
  logic [ADDR_WIDTH-1:0]   aw_addr;
  logic [7:0]              aw_len;
  logic [2:0]              aw_size;
  logic [1:0]              aw_burst;
  logic                    aw_lock;
  logic [3:0]              aw_cache;
  logic [2:0]              aw_prot;
  logic                    aw_valid;
  logic                    aw_ready;

  logic [DATA_WIDTH-1:0]   w_data;
  logic [DATA_WIDTH/8-1:0] w_strb;
  logic                    w_last;
  logic                    w_valid;
  logic                    w_ready;

  logic [ID_WIDTH-1:0]     b_id;
  logic [1:0]              b_resp;
  logic                    b_user;
  logic                    b_valid;
  logic                    b_ready;

  logic [ID_WIDTH-1:0]     ar_id;
  logic [ADDR_WIDTH-1:0]   ar_addr;
  logic [7:0]              ar_len;
  logic [2:0]              ar_size;
  logic [1:0]              ar_burst;
  logic                    ar_lock;
  logic [3:0]              ar_cache;
  logic [2:0]              ar_prot;
  logic                    ar_valid;
  logic                    ar_ready;

  logic [ID_WIDTH-1:0]     r_id;
  logic [DATA_WIDTH-1:0]   r_data;
  logic [1:0]              r_resp;
  logic                    r_last;
  logic                    r_user;
  logic                    r_valid;
  logic                    r_ready;

  modport master (
    output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot, aw_valid,
    input  aw_ready,
    output w_data, w_strb, w_last, w_valid,
    input  w_ready,
    input  b_id, b_resp, b_user, b_valid,
    output b_ready,
    output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot, ar_valid,
    input  ar_ready,
    input  r_id, r_data, r_resp, r_last, r_user, r_valid,
    output r_ready
  );

  modport slave (
    input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot, aw_valid,
    output aw_ready,
    input  w_data, w_strb, w_last, w_valid,
    output w_ready,
    output b_id, b_resp, b_user, b_valid,
    input  b_ready,
    input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot, ar_valid,
    output ar_ready,
    output r_id, r_data, r_resp, r_last, r_user, r_valid,
    input  r_ready
  );
endinterface

// File: rtl/nasti_mem_slave.sv
// nasti_mem_slave: NASTI slave backed by a word-addressed memory of MEM_BYTES
// bytes starting at BASE_ADDR. Independent write (AW/W/B) and read (AR/R)
// engines; every burst is treated as INCR with full-width beats.
// Ports:
//   aclk    - clock
//   aresetn - asynchronous active-low reset
//   s       - nasti_channel.slave; drives aw_ready, w_ready, b_*, ar_ready, r_*
// Beats outside [BASE_ADDR, BASE_ADDR+MEM_BYTES) return SLVERR (per beat on R,
// sticky per burst on B) and never touch memory.
module nasti_mem_slave #(
  parameter int              ADDR_WIDTH = 64,
  parameter int              DATA_WIDTH = 64,
  parameter int              ID_WIDTH   = 1,
  parameter int              MEM_BYTES  = 8192,
  parameter longint unsigned BASE_ADDR  = 0
) (
  input logic         aclk,
  input logic         aresetn,
  nasti_channel.slave s
);
  localparam int BPB   = DATA_WIDTH / 8;
  localparam int OFF_W = $clog2(BPB);
  localparam int WORDS = MEM_BYTES / BPB;
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] SPAN = ADDR_WIDTH'(MEM_BYTES);
  localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(BPB);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_e;

  logic [DATA_WIDTH-1:0] mem [WORDS];

  // Addresses below BASE wrap to a huge offset, so one unsigned compare covers
  // both bounds (the array always fits inside the address space).
  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    return (a - BASE) < SPAN;
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a);
    return IDX_W'((a - BASE) >> OFF_W);
  endfunction

  // Size, burst type and attributes do not change behaviour.
  logic unused_fields;
  assign unused_fields = ^{s.aw_size, s.aw_burst, s.aw_lock, s.aw_cache, s.aw_prot,
                           s.ar_size, s.ar_burst, s.ar_lock, s.ar_cache, s.ar_prot};

  // ---------------------------------------------------------------- write engine
  w_state_e              w_state_q, w_state_d;
  logic [ID_WIDTH-1:0]   w_id_q, w_id_d, b_id_q, b_id_d;
  logic [ADDR_WIDTH-1:0] w_addr_q, w_addr_d;
  logic [7:0]            w_len_q, w_len_d, w_cnt_q, w_cnt_d;
  logic                  w_err_q, w_err_d;
  logic                  aw_ready_q, aw_ready_d, w_ready_q, w_ready_d, b_valid_q, b_valid_d;
  logic [1:0]            b_resp_q, b_resp_d;
  logic                  aw_fire, w_fire, b_fire, w_last_beat, w_beat_err;

  assign aw_fire     = s.aw_valid && aw_ready_q;
  assign w_fire      = s.w_valid && w_ready_q;
  assign b_fire      = b_valid_q && s.b_ready;
  assign w_last_beat = (w_cnt_q == w_len_q);
  // A misplaced w_last flags the burst but never shortens or extends it.
  assign w_beat_err  = !in_range(w_addr_q) || (s.w_last != w_last_beat);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) w_state_q <= W_IDLE;
    else          w_state_q <= w_state_d;
  end

  always_comb begin
    w_state_d = w_state_q;
    unique case (w_state_q)
      W_IDLE:  if (aw_fire)                w_state_d = W_DATA;
      W_DATA:  if (w_fire && w_last_beat)  w_state_d = W_RESP;
      W_RESP:  if (b_fire)                 w_state_d = W_IDLE;
      default:                             w_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    w_id_d   = w_id_q;
    w_addr_d = w_addr_q;
    w_len_d  = w_len_q;
    w_cnt_d  = w_cnt_q;
    w_err_d  = w_err_q;
    b_id_d   = b_id_q;
    b_resp_d = b_resp_q;
    if (aw_fire) begin
      w_id_d   = s.aw_id;
      w_addr_d = s.aw_addr;
      w_len_d  = s.aw_len;
      w_cnt_d  = 8'd0;
      w_err_d  = 1'b0;
    end
    if (w_fire) begin
      w_addr_d = w_addr_q + STEP;
      w_cnt_d  = w_cnt_q + 8'd1;
      w_err_d  = w_err_q | w_beat_err;
      if (w_last_beat) begin
        b_id_d   = w_id_q;
        b_resp_d = (w_err_q | w_beat_err) ? RESP_SLVERR : RESP_OKAY;
      end
    end
    aw_ready_d = (w_state_d == W_IDLE);
    w_ready_d  = (w_state_d == W_DATA);
    b_valid_d  = (w_state_d == W_RESP);
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      w_id_q <= '0; w_addr_q <= '0; w_len_q <= '0; w_cnt_q <= '0; w_err_q <= 1'b0;
      aw_ready_q <= 1'b0; w_ready_q <= 1'b0; b_valid_q <= 1'b0;
      b_id_q <= '0; b_resp_q <= RESP_OKAY;
    end else begin
      w_id_q <= w_id_d; w_addr_q <= w_addr_d; w_len_q <= w_len_d; w_cnt_q <= w_cnt_d;
      w_err_q <= w_err_d;
      aw_ready_q <= aw_ready_d; w_ready_q <= w_ready_d; b_valid_q <= b_valid_d;
      b_id_q <= b_id_d; b_resp_q <= b_resp_d;
    end
  end

  always_ff @(posedge aclk) begin
    if (w_fire && in_range(w_addr_q)) begin
      for (int i = 0; i < BPB; i++) begin
        if (s.w_strb[i]) mem[word_idx(w_addr_q)][8*i +: 8] <= s.w_data[8*i +: 8];
      end
    end
  end

  // ----------------------------------------------------------------- read engine
  r_state_e              r_state_q, r_state_d;
  logic [ID_WIDTH-1:0]   r_id_q, r_id_d;
  logic [ADDR_WIDTH-1:0] r_addr_q, r_addr_d, rd_addr;
  logic [7:0]            r_len_q, r_len_d, r_cnt_q, r_cnt_d;
  logic                  ar_ready_q, ar_ready_d, r_valid_q, r_valid_d, r_last_q, r_last_d;
  logic [DATA_WIDTH-1:0] r_data_q, r_data_d, rd_word;
  logic [1:0]            r_resp_q, r_resp_d;
  logic                  ar_fire, r_fire, r_last_beat, rd_ok, r_load;

  assign ar_fire     = s.ar_valid && ar_ready_q;
  assign r_fire      = r_valid_q && s.r_ready;
  assign r_last_beat = (r_cnt_q == r_len_q);
  // r_addr_q always holds the address of the next beat to load.
  assign rd_addr     = (r_state_q == R_IDLE) ? s.ar_addr : r_addr_q;
  assign rd_ok       = in_range(rd_addr);
  // Combinational read sees memory before this cycle's write commits.
  assign rd_word     = mem[word_idx(rd_addr)];
  assign r_load      = ar_fire || (r_fire && !r_last_beat);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) r_state_q <= R_IDLE;
    else          r_state_q <= r_state_d;
  end

  always_comb begin
    r_state_d = r_state_q;
    unique case (r_state_q)
      R_IDLE:  if (ar_fire)               r_state_d = R_DATA;
      R_DATA:  if (r_fire && r_last_beat) r_state_d = R_IDLE;
      default:                            r_state_d = R_IDLE;
    endcase
  end

  always_comb begin
    r_id_d   = r_id_q;
    r_len_d  = r_len_q;
    r_cnt_d  = r_cnt_q;
    r_addr_d = r_addr_q;
    r_data_d = r_data_q;
    r_resp_d = r_resp_q;
    r_last_d = r_last_q;
    if (ar_fire) begin
      r_id_d   = s.ar_id;
      r_len_d  = s.ar_len;
      r_cnt_d  = 8'd0;
      r_last_d = (s.ar_len == 8'd0);
    end else if (r_fire) begin
      r_cnt_d  = r_cnt_q + 8'd1;
      r_last_d = !r_last_beat && ((r_cnt_q + 8'd1) == r_len_q);
    end
    if (r_load) begin
      r_data_d = rd_ok ? rd_word : '0;
      r_resp_d = rd_ok ? RESP_OKAY : RESP_SLVERR;
      r_addr_d = rd_addr + STEP;
    end
    ar_ready_d = (r_state_d == R_IDLE);
    r_valid_d  = (r_state_d == R_DATA);
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_id_q <= '0; r_len_q <= '0; r_cnt_q <= '0; r_addr_q <= '0;
      r_data_q <= '0; r_resp_q <= RESP_OKAY; r_last_q <= 1'b0;
      ar_ready_q <= 1'b0; r_valid_q <= 1'b0;
    end else begin
      r_id_q <= r_id_d; r_len_q <= r_len_d; r_cnt_q <= r_cnt_d; r_addr_q <= r_addr_d;
      r_data_q <= r_data_d; r_resp_q <= r_resp_d; r_last_q <= r_last_d;
      ar_ready_q <= ar_ready_d; r_valid_q <= r_valid_d;
    end
  end

  assign s.aw_ready = aw_ready_q;
  assign s.w_ready  = w_ready_q;
  assign s.b_valid  = b_valid_q;
  assign s.b_id     = b_id_q;
  assign s.b_resp   = b_resp_q;
  assign s.b_user   = 1'b0;
  assign s.ar_ready = ar_ready_q;
  assign s.r_valid  = r_valid_q;
  assign s.r_id     = r_id_q;
  assign s.r_data   = r_data_q;
  assign s.r_resp   = r_resp_q;
  assign s.r_last   = r_last_q;
  assign s.r_user   = 1'b0;
endmodule

// File: tb/tb_nasti_mem_slave.sv
// Testbench for nasti_mem_slave: directed test-plan steps followed by random
// bursts, all checked against a byte-merging memory model held in this bench.
module tb_nasti_mem_slave;
  localparam int              AW        = 64;
  localparam int              DW        = 64;
  localparam int              IW        = 1;
  localparam int              MEM_BYTES = 8192;
  localparam longint unsigned BASE      = 0;
  localparam int              WORDS     = MEM_BYTES / 8;
  localparam int              TMO       = 2000;

  // ------------------------------------------------------------ clock / reset
  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;

  nasti_channel #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) bus ();

  nasti_mem_slave #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW),
    .MEM_BYTES(MEM_BYTES), .BASE_ADDR(BASE)
  ) dut (
    .aclk(aclk), .aresetn(aresetn), .s(bus.slave)
  );

  // -------------------------------------------------------- model / scoreboard
  int            checks = 0;
  int            failures = 0;
  logic [63:0]   model [WORDS];
  logic [63:0]   wdata_q [$];
  logic [7:0]    wstrb_q [$];
  logic [IW+1:0] exp_q [$];   // expected B: {id, resp}

  function automatic bit in_rng(input logic [63:0] a);
    return (a >= BASE) && (a < BASE + 64'(MEM_BYTES));
  endfunction

  function automatic int widx(input logic [63:0] a);
    return int'((a - BASE) / 8);
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic timeout_fail(input string tag);
    checks++;
    failures++;
    $error("FAIL %s: no handshake within %0d cycles", tag, TMO);
  endtask

  task automatic idle_inputs();
    bus.aw_valid = 0; bus.aw_id = '0; bus.aw_addr = '0; bus.aw_len = '0;
    bus.aw_size = 3'd3; bus.aw_burst = 2'b01; bus.aw_lock = 0; bus.aw_cache = '0; bus.aw_prot = '0;
    bus.w_valid = 0; bus.w_data = '0; bus.w_strb = '0; bus.w_last = 0;
    bus.b_ready = 0;
    bus.ar_valid = 0; bus.ar_id = '0; bus.ar_addr = '0; bus.ar_len = '0;
    bus.ar_size = 3'd3; bus.ar_burst = 2'b01; bus.ar_lock = 0; bus.ar_cache = '0; bus.ar_prot = '0;
    bus.r_ready = 0;
  endtask

  task automatic cycle();
    @(posedge aclk);
    #1;
  endtask

  task automatic fill_random(input int len, input bit rnd_strb);
    wdata_q.delete();
    wstrb_q.delete();
    for (int b = 0; b <= len; b++) begin
      wdata_q.push_back({$urandom, $urandom});
      wstrb_q.push_back(rnd_strb ? 8'($urandom) : 8'hFF);
    end
  endtask

  // ------------------------------------------------------------ driver tasks
  // All tasks start and end 1 time unit after a rising edge.
  task automatic wait_ready(input string tag, ref logic rdy, output bit ok);
    int t;
    t = 0;
    while (!rdy && t < TMO) begin cycle(); t++; end
    ok = (t < TMO);
    if (!ok) timeout_fail(tag);
    else cycle();
  endtask

  task automatic model_write(input logic [63:0] a, input logic [63:0] d, input logic [7:0] st);
    for (int k = 0; k < 8; k++) if (st[k]) model[widx(a)][8*k +: 8] = d[8*k +: 8];
  endtask

  // flip: index of the beat whose w_last is inverted (-1 for none).
  task automatic write_burst(input logic [63:0] addr, input int len, input logic [IW-1:0] id,
                             input int flip, input int gap_max, input int bready_pct);
    logic [63:0] a;
    bit err, ok, seen, done;
    logic [1:0] h_resp;
    logic [IW-1:0] h_id;
    logic [IW+1:0] e;
    int t;
    a = addr; err = 0;
    for (int b = 0; b <= len; b++) begin
      if (in_rng(a)) model_write(a, wdata_q[b], wstrb_q[b]);
      else err = 1;
      if (b == flip) err = 1;
      a = a + 64'd8;
    end
    exp_q.push_back({id, err ? 2'b10 : 2'b00});

    bus.aw_valid = 1; bus.aw_addr = addr; bus.aw_len = 8'(len); bus.aw_id = id;
    wait_ready("aw_handshake", bus.aw_ready, ok);
    bus.aw_valid = 0;
    if (!ok) return;

    for (int b = 0; b <= len; b++) begin
      repeat ($urandom_range(0, gap_max)) cycle();
      bus.w_valid = 1; bus.w_data = wdata_q[b]; bus.w_strb = wstrb_q[b];
      bus.w_last = (b == len) ^ (b == flip);
      wait_ready("w_handshake", bus.w_ready, ok);
      bus.w_valid = 0;
      if (!ok) return;
    end

    t = 0; seen = 0; done = 0;
    while (!done && t < TMO) begin
      bus.b_ready = ($urandom_range(0, 99) < bready_pct);
      if (bus.b_valid) begin
        if (seen) begin
          check("b_resp_stable", bus.b_resp, h_resp);
          check("b_id_stable", bus.b_id, h_id);
        end else check("w_ready_low_in_resp", bus.w_ready, 0);
        seen = 1; h_resp = bus.b_resp; h_id = bus.b_id;
        if (bus.b_ready) begin
          e = exp_q.pop_front();
          check("b_resp", bus.b_resp, e[1:0]);
          check("b_id", bus.b_id, e[IW+1:2]);
          cycle();
          bus.b_ready = 0;
          check("aw_ready_after_b", bus.aw_ready, 1);
          done = 1;
        end
      end
      if (!done) begin cycle(); t++; end
    end
    bus.b_ready = 0;
    if (!done) timeout_fail("b_handshake");
  endtask

  task automatic read_burst(input logic [63:0] addr, input int len, input logic [IW-1:0] id,
                            input int rready_pct, output int bubbles);
    logic [63:0] a, h_data, e_data;
    logic [1:0]  h_resp;
    logic        h_last;
    logic [IW-1:0] h_id;
    bit ok, held;
    int beat, t;
    bubbles = 0;
    bus.ar_valid = 1; bus.ar_addr = addr; bus.ar_len = 8'(len); bus.ar_id = id;
    wait_ready("ar_handshake", bus.ar_ready, ok);
    bus.ar_valid = 0;
    if (!ok) return;
    check("r_valid_latency", bus.r_valid, 1);
    check("ar_ready_busy", bus.ar_ready, 0);

    a = addr; beat = 0; held = 0; t = 0;
    while (beat <= len && t < TMO) begin
      bus.r_ready = ($urandom_range(0, 99) < rready_pct);
      if (bus.r_valid) begin
        if (held) begin
          check("r_data_stable", bus.r_data, h_data);
          check("r_resp_stable", bus.r_resp, h_resp);
          check("r_last_stable", bus.r_last, h_last);
          check("r_id_stable", bus.r_id, h_id);
        end
        if (bus.r_ready) begin
          e_data = in_rng(a) ? model[widx(a)] : 64'd0;
          check("r_data", bus.r_data, e_data);
          check("r_resp", bus.r_resp, in_rng(a) ? 2'b00 : 2'b10);
          check("r_last", bus.r_last, beat == len);
          check("r_id", bus.r_id, id);
          beat++; a = a + 64'd8; held = 0;
        end else begin
          held = 1; h_data = bus.r_data; h_resp = bus.r_resp; h_last = bus.r_last; h_id = bus.r_id;
        end
      end else bubbles++;
      cycle(); t++;
    end
    bus.r_ready = 0;
    if (beat <= len) timeout_fail("r_beats");
    else begin
      check("r_valid_after_last", bus.r_valid, 0);
      check("ar_ready_after_last", bus.ar_ready, 1);
    end
  endtask

  // -------------------------------------------------------------- stimulus
  initial begin
    int bub;
    bit ok;
    logic [63:0] a;
    idle_inputs();

    // Reset values
    #12;
    check("rst_aw_ready", bus.aw_ready, 0);
    check("rst_w_ready", bus.w_ready, 0);
    check("rst_b_valid", bus.b_valid, 0);
    check("rst_ar_ready", bus.ar_ready, 0);
    check("rst_r_valid", bus.r_valid, 0);
    check("rst_r_last", bus.r_last, 0);
    check("rst_b_resp", bus.b_resp, 0);
    check("rst_r_resp", bus.r_resp, 0);
    check("rst_b_id", bus.b_id, 0);
    check("rst_r_id", bus.r_id, 0);
    check("rst_r_data", bus.r_data, 0);
    @(posedge aclk); #3; aresetn = 1; #1;
    check("aw_ready_before_edge", bus.aw_ready, 0);
    cycle();
    check("aw_ready_after_release", bus.aw_ready, 1);
    check("ar_ready_after_release", bus.ar_ready, 1);

    // Give every word a known value
    for (int i = 0; i < 4; i++) begin
      fill_random(255, 0);
      write_burst(64'(i * 2048), 255, 1'b0, -1, 0, 100);
    end

    // Basic 4-beat write / read with echoed id
    wdata_q = '{64'h11, 64'h22, 64'h33, 64'h44};
    wstrb_q = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
    write_burst(64'h0, 3, 1'b1, -1, 0, 100);
    read_burst(64'h0, 3, 1'b1, 100, bub);

    // Byte strobes: upper half survives a partial-strobe write of zeros
    wdata_q = '{64'hFFFF_FFFF_FFFF_FFFF}; wstrb_q = '{8'hFF};
    write_burst(64'h40, 0, 1'b0, -1, 0, 100);
    wdata_q = '{64'h0}; wstrb_q = '{8'h0F};
    write_burst(64'h40, 0, 1'b1, -1, 0, 100);
    read_burst(64'h40, 0, 1'b0, 100, bub);

    // 256-beat burst, full throughput
    fill_random(255, 0);
    write_burst(64'h100, 255, 1'b1, -1, 0, 100);
    read_burst(64'h100, 255, 1'b0, 100, bub);
    check("r_no_bubbles", bub, 0);

    // Burst straddling the top of memory
    read_burst(64'(MEM_BYTES - 16), 3, 1'b1, 100, bub);
    fill_random(3, 0);
    write_burst(64'(MEM_BYTES - 16), 3, 1'b0, -1, 1, 100);
    read_burst(64'(MEM_BYTES - 16), 1, 1'b0, 100, bub);

    // Early w_last still takes len+1 beats and flags SLVERR
    fill_random(1, 0);
    write_burst(64'h200, 1, 1'b1, 0, 0, 100);
    read_burst(64'h200, 1, 1'b1, 100, bub);

    // Backpressure on R and B
    fill_random(7, 1);
    write_burst(64'h300, 7, 1'b0, -1, 2, 30);
    read_burst(64'h300, 7, 1'b1, 30, bub);

    // Random bursts, some running off the end, some with misplaced w_last
    for (int n = 0; n < 24; n++) begin
      int len;
      logic [IW-1:0] id;
      a = 64'($urandom_range(0, MEM_BYTES + 63));
      len = $urandom_range(0, 15);
      id = IW'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        fill_random(len, 1);
        write_burst(a, len, id, ($urandom_range(0, 7) == 0) ? $urandom_range(0, len) : -1,
                    $urandom_range(0, 2), $urandom_range(30, 100));
      end else begin
        read_burst(a, len, id, $urandom_range(30, 100), bub);
      end
    end

    // Reset mid write burst and mid read burst
    fill_random(7, 0);
    bus.aw_valid = 1; bus.aw_addr = 64'h1000; bus.aw_len = 8'd7; bus.aw_id = 1'b0;
    wait_ready("aw_handshake_rst", bus.aw_ready, ok);
    bus.aw_valid = 0;
    a = 64'h1000;
    for (int b = 0; b < 3; b++) begin
      bus.w_valid = 1; bus.w_data = wdata_q[b]; bus.w_strb = 8'hFF; bus.w_last = 0;
      wait_ready("w_handshake_rst", bus.w_ready, ok);
      if (ok) model_write(a, wdata_q[b], 8'hFF);
      a = a + 64'd8;
    end
    bus.w_valid = 0;
    bus.ar_valid = 1; bus.ar_addr = 64'h200; bus.ar_len = 8'd255; bus.ar_id = 1'b1;
    wait_ready("ar_handshake_rst", bus.ar_ready, ok);
    bus.ar_valid = 0;
    bus.r_ready = 1;
    repeat (5) cycle();
    #2;
    aresetn = 0;
    idle_inputs();
    #1;
    check("arst_aw_ready", bus.aw_ready, 0);
    check("arst_w_ready", bus.w_ready, 0);
    check("arst_b_valid", bus.b_valid, 0);
    check("arst_ar_ready", bus.ar_ready, 0);
    check("arst_r_valid", bus.r_valid, 0);
    check("arst_r_last", bus.r_last, 0);
    @(posedge aclk); #3; aresetn = 1;
    cycle();
    check("aw_ready_after_arst", bus.aw_ready, 1);
    check("ar_ready_after_arst", bus.ar_ready, 1);
    read_burst(64'h1000, 7, 1'b0, 100, bub);
    fill_random(3, 1);
    write_burst(64'h1800, 3, 1'b1, -1, 1, 60);
    read_burst(64'h1800, 3, 1'b1, 60, bub);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
